// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl
// Packet controller sitting between the UART receive stream and the UART
// transmit stream of the UART ALU.  It parses command packets, echoes
// payloads, sums add operands internally, hands multiply/divide to an
// external arithmetic unit and returns 32-bit results little-endian.
//
// Packet: opcode, reserved, LEN low, LEN high, then LEN-4 payload bytes.
//   0xEC echo, 0xA1 add, 0xB1 multiply, 0xC1 divide.
//
// Ports:
//   clk_i, reset_ni         clock, asynchronous active-low reset
//   s_axis_*                RX byte stream from uart_rx (tdata/tvalid/tready)
//   m_axis_*                TX byte stream to uart_tx (tdata/tvalid/tready)
//   alu_req_valid_o/ready_i request handshake to the arithmetic unit
//   alu_op_o                0 = multiply (low word), 1 = unsigned divide
//   alu_a_o, alu_b_o        operands
//   alu_rsp_valid_i/data_i  one-cycle result strobe and result
//   busy_o                  high whenever a packet is in progress
//   err_o                   one-cycle pulse on a malformed packet
module uart_alu_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  alu_req_valid_o,
    input  logic                  alu_req_ready_i,
    output logic                  alu_op_o,
    output logic [WORD_WIDTH-1:0] alu_a_o,
    output logic [WORD_WIDTH-1:0] alu_b_o,
    input  logic                  alu_rsp_valid_i,
    input  logic [WORD_WIDTH-1:0] alu_rsp_data_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int LEN_WIDTH = 2 * DATA_WIDTH;

    localparam logic [DATA_WIDTH-1:0] OP_ECHO = 8'hEC;
    localparam logic [DATA_WIDTH-1:0] OP_ADD  = 8'hA1;
    localparam logic [DATA_WIDTH-1:0] OP_MUL  = 8'hB1;
    localparam logic [DATA_WIDTH-1:0] OP_DIV  = 8'hC1;

    typedef enum logic [3:0] {
        ST_OPC,
        ST_RSV,
        ST_LENL,
        ST_LENH,
        ST_ECHO_RX,
        ST_ECHO_TX,
        ST_OPND,
        ST_REQ,
        ST_WAIT,
        ST_SEND,
        ST_DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] len_lo;
    logic [DATA_WIDTH-1:0] echo_byte;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  full_len;
    logic [LEN_WIDTH-1:0]  payload_len;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_inc;
    logic [WORD_WIDTH-1:0] word_sr;
    logic [WORD_WIDTH-1:0] word_new;
    logic [WORD_WIDTH-1:0] acc;
    logic [WORD_WIDTH-1:0] a_reg;
    logic [WORD_WIDTH-1:0] b_reg;
    logic [WORD_WIDTH-1:0] result;
    logic [1:0]            send_idx;
    logic                  started;
    logic                  err_q;
    logic                  len_ok;
    logic                  len_err;
    logic                  rx_fire;
    logic                  tx_fire;

    // LEN as it completes on the LENH byte, before it is registered.
    assign full_len    = {s_axis_tdata, len_lo};
    assign payload_len = len - LEN_WIDTH'(4);
    assign cnt_inc     = cnt + LEN_WIDTH'(1);
    // Little-endian: each new byte enters at the top, so after four bytes
    // the first one has reached the least significant position.
    assign word_new    = {s_axis_tdata, word_sr[WORD_WIDTH-1:DATA_WIDTH]};

    assign rx_fire = s_axis_tvalid & s_axis_tready;
    assign tx_fire = m_axis_tvalid & m_axis_tready;

    assign busy_o   = (state != ST_OPC);
    assign err_o    = err_q;
    assign alu_op_o = (opcode == OP_DIV);
    assign alu_a_o  = a_reg;
    assign alu_b_o  = b_reg;

    // Length validation per opcode; (LEN-4)%4==0 is the same as LEN%4==0.
    always_comb begin
        len_ok = 1'b0;
        case (opcode)
            OP_ECHO:        len_ok = (full_len >= LEN_WIDTH'(4));
            OP_ADD:         len_ok = (full_len >= LEN_WIDTH'(8)) && (full_len[1:0] == 2'b00);
            OP_MUL, OP_DIV: len_ok = (full_len == LEN_WIDTH'(12));
            default:        len_ok = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_OPC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.  Branches test the partner's
    // valid/ready directly because our own side is known from the state.
    // OPC waits for 'started' so tready stays low through the first cycle
    // after reset release.
    always_comb begin
        state_next      = state;
        s_axis_tready   = 1'b0;
        m_axis_tvalid   = 1'b0;
        m_axis_tdata    = '0;
        alu_req_valid_o = 1'b0;
        len_err         = 1'b0;
        case (state)
            ST_OPC: begin
                s_axis_tready = started;
                if (started && s_axis_tvalid) state_next = ST_RSV;
            end
            ST_RSV: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) state_next = ST_LENL;
            end
            ST_LENL: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) state_next = ST_LENH;
            end
            ST_LENH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (!len_ok) begin
                        len_err    = 1'b1;
                        state_next = (full_len > LEN_WIDTH'(4)) ? ST_DROP : ST_OPC;
                    end else if (opcode == OP_ECHO) begin
                        state_next = (full_len == LEN_WIDTH'(4)) ? ST_OPC : ST_ECHO_RX;
                    end else begin
                        state_next = ST_OPND;
                    end
                end
            end
            ST_ECHO_RX: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) state_next = ST_ECHO_TX;
            end
            ST_ECHO_TX: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = echo_byte;
                // cnt already counts the byte being sent.
                if (m_axis_tready) begin
                    state_next = (cnt == payload_len) ? ST_OPC : ST_ECHO_RX;
                end
            end
            ST_OPND: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (cnt_inc == payload_len)) begin
                    state_next = (opcode == OP_ADD) ? ST_SEND : ST_REQ;
                end
            end
            ST_REQ: begin
                alu_req_valid_o = 1'b1;
                if (alu_req_ready_i) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_rsp_valid_i) state_next = ST_SEND;
            end
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                case (send_idx)
                    2'd0:    m_axis_tdata = result[DATA_WIDTH-1:0];
                    2'd1:    m_axis_tdata = result[2*DATA_WIDTH-1:DATA_WIDTH];
                    2'd2:    m_axis_tdata = result[3*DATA_WIDTH-1:2*DATA_WIDTH];
                    default: m_axis_tdata = result[4*DATA_WIDTH-1:3*DATA_WIDTH];
                endcase
                if (m_axis_tready && (send_idx == 2'd3)) state_next = ST_OPC;
            end
            ST_DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (cnt_inc == payload_len)) state_next = ST_OPC;
            end
            default: state_next = ST_OPC;
        endcase
    end

    // Datapath: header capture, payload counting, operand assembly and
    // result bookkeeping.  send_idx wraps to 0 after the fourth TX byte,
    // so it is always 0 when SEND is entered.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            started   <= 1'b0;
            err_q     <= 1'b0;
            opcode    <= '0;
            len_lo    <= '0;
            len       <= '0;
            cnt       <= '0;
            echo_byte <= '0;
            word_sr   <= '0;
            acc       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            result    <= '0;
            send_idx  <= '0;
        end else begin
            started <= 1'b1;
            err_q   <= len_err;
            case (state)
                ST_OPC: begin
                    if (rx_fire) opcode <= s_axis_tdata;
                end
                ST_LENL: begin
                    if (rx_fire) len_lo <= s_axis_tdata;
                end
                ST_LENH: begin
                    if (rx_fire) begin
                        len     <= full_len;
                        cnt     <= '0;
                        acc     <= '0;
                        word_sr <= '0;
                    end
                end
                ST_ECHO_RX: begin
                    if (rx_fire) begin
                        echo_byte <= s_axis_tdata;
                        cnt       <= cnt_inc;
                    end
                end
                ST_OPND: begin
                    if (rx_fire) begin
                        word_sr <= word_new;
                        cnt     <= cnt_inc;
                        if (cnt[1:0] == 2'b11) begin
                            if (opcode == OP_ADD) begin
                                acc    <= acc + word_new;
                                result <= acc + word_new;
                            end else if (!cnt[2]) begin
                                a_reg <= word_new;
                            end else begin
                                b_reg <= word_new;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (alu_rsp_valid_i) result <= alu_rsp_data_i;
                end
                ST_SEND: begin
                    if (tx_fire) send_idx <= send_idx + 2'd1;
                end
                ST_DROP: begin
                    if (rx_fire) cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Packet controller between the UART receive stream and the UART transmit stream of the UART ALU.
- Parses command packets from the RX AXI-stream.
- Echoes payloads, accumulates additions internally, and schedules multiply/divide on an external arithmetic unit over a valid/ready request and valid response interface.
- Serializes 32-bit results back to the TX AXI-stream, little-endian.

Parameters:
- DATA_WIDTH, 8: byte width of both AXI-streams. Only 8 is supported.
- WORD_WIDTH, 32: operand and result width. Must be 4*DATA_WIDTH.

Ports:
- clk_i  in  1  single clock.
- reset_ni  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  byte from uart_rx.
- s_axis_tvalid  in  1  RX byte valid.
- s_axis_tready  out  1  controller accepts the byte.
- m_axis_tdata  out  DATA_WIDTH  byte to uart_tx.
- m_axis_tvalid  out  1  TX byte valid.
- m_axis_tready  in  1  uart_tx accepts the byte.
- alu_req_valid_o  out  1  operands and op are valid.
- alu_req_ready_i  in  1  arithmetic unit accepts the request.
- alu_op_o  out  1  0 = multiply (low 32 bits), 1 = divide (unsigned quotient).
- alu_a_o  out  WORD_WIDTH  operand A.
- alu_b_o  out  WORD_WIDTH  operand B.
- alu_rsp_valid_i  in  1  one-cycle result strobe.
- alu_rsp_data_i  in  WORD_WIDTH  result.
- busy_o  out  1  high in every state except OPC.
- err_o  out  1  one-cycle pulse on packet error.

Behaviour:
- Packet layout:
  - byte0 opcode; byte1 reserved (ignored); byte2/byte3 LEN, little-endian, total packet length including the 4-byte header.
  - Payload is LEN-4 bytes. Words are little-endian.
- Opcodes:
  - 0xEC echo.
  - 0xA1 add.
  - 0xB1 mul.
  - 0xC1 div.
- Reset: state OPC; all counters, registers and outputs 0. This includes s_axis_tready, m_axis_tvalid, alu_req_valid_o, busy_o and err_o.
- Handshake rules:
  - A byte transfers when tvalid and tready are both high on a rising edge.
  - s_axis_tready is high only in OPC, RSV, LENL, LENH, ECHO_RX, OPND and DROP.
  - m_axis_tvalid, once high, holds with m_axis_tdata stable until m_axis_tready.
  - alu_req_valid_o, once high, holds with op, A and B stable until alu_req_ready_i.
- State transitions:
  - OPC: latch the opcode, then go to RSV.
  - RSV: go to LENL.
  - LENL, LENH: latch LEN. On the LENH handshake, validate:
    - echo: LEN>=4.
    - add: LEN>=8 and (LEN-4)%4==0.
    - mul/div: LEN==12.
    - Unknown opcode or failed check: err_o pulses the cycle after LENH; go to DROP if LEN>4, else to OPC.
    - Echo with LEN==4: return to OPC with no output.
- ECHO_RX / ECHO_TX:
  - Accept one byte, present it on m_axis next cycle, wait for tready, repeat.
  - Return to OPC after LEN-4 bytes.
  - Exactly one byte is in flight at a time.
- OPND: shift bytes into a 32-bit word register. On every 4th byte:
  - add: acc <= acc + word, mod 2^32. acc is cleared on entering OPND.
  - mul/div: the first word goes to A, the second to B.
  - After the final payload byte, add goes to SEND with acc; mul/div goes to REQ.
- REQ: assert alu_req_valid_o. After handshake go to WAIT.
- WAIT: on alu_rsp_valid_i, latch the result and go to SEND. Responses arriving in any other state are ignored.
- SEND: emit result bytes [7:0], [15:8], [23:16], [31:24] in order; after the 4th handshake go to OPC.
- DROP: consume LEN-4 bytes, discarding them, then go to OPC.
- Byte counter is 16 bits and compares against LEN-4. No wrap: LEN=0xFFFF is legal for echo.
- Error conditions do not produce TX output.
- Back-to-back packets: OPC is ready the cycle after returning; no idle byte is required.
- An asynchronous reset mid-packet aborts immediately: outputs go low and any partial byte or request is discarded.

Test Plan:
- Echo: RX EC 00 07 00 41 42 43 -> TX 41 42 43; err_o never pulses; busy_o low after the last TX handshake.
- Add: RX A1 00 10 00, then words FFFFFFFF, 00000002, 00000005 -> TX 06 00 00 00 (wrap mod 2^32).
- Mul with ready stall: RX B1 00 0C 00 03 00 00 00 07 00 00 00; alu_req_ready_i low 5 cycles -> request held stable with op=0, A=3, B=7. Response 0x15 -> TX 15 00 00 00.
- Div: RX C1 00 0C 00 with A=100, B=7; response 14 -> TX 0E 00 00 00. A following echo packet sent back-to-back is handled correctly.
- Errors:
  - Opcode 0x55 with LEN=6 -> err_o one pulse, 2 bytes dropped, no TX, next packet parsed.
  - Add with LEN=9 -> err_o, 5 bytes dropped.
- TX backpressure and reset: m_axis_tready toggled randomly during SEND -> no byte lost or duplicated. reset_ni asserted mid-OPND -> all outputs 0 asynchronously; the next packet is correct.
